// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB with handshaked
// instruction fetch and data-memory access, one retire pulse per instruction.
module multi_cycle_mips #(
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREG     = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       IR_addr,
  output logic              IR_req,
  input  logic [31:0]       IR,
  input  logic              IR_ack,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       Data2Mem,
  input  logic [31:0]       ReadDataMem,
  input  logic              mem_ack,
  output logic              retire
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  state_t state, state_nxt;

  logic [31:0] pc, ir;
  logic [31:0] rs_val, rt_val, simm;
  logic [31:0] alu_out, alu_res, mdr;
  logic [31:0] rs_rd, rt_rd;
  logic [31:0] wr_data;
  logic [4:0]  wr_idx;
  logic        rf_we;

  // Register 0 has no storage; it is synthesized as a constant zero read.
  logic [NREG-1:1][31:0] regs;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       is_r_ok, is_addi, is_lw, is_sw, is_beq, is_j;
  logic       unused_shamt;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    is_r_ok = 1'b0;
    if (op == OP_R) begin
      case (funct)
        F_ADD, F_SUB, F_AND, F_OR, F_SLT: is_r_ok = 1'b1;
        default:                          is_r_ok = 1'b0;
      endcase
    end
  end

  assign is_addi = (op == OP_ADDI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);

  // Specifiers at or above NREG fall through and read as zero.
  always_comb begin
    rs_rd = '0;
    rt_rd = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs == 5'(i)) rs_rd = regs[i];
      if (rt == 5'(i)) rt_rd = regs[i];
    end
  end

  always_comb begin
    alu_res = rs_val + simm;
    if (op == OP_R) begin
      case (funct)
        F_ADD:   alu_res = rs_val + rt_val;
        F_SUB:   alu_res = rs_val - rt_val;
        F_AND:   alu_res = rs_val & rt_val;
        F_OR:    alu_res = rs_val | rt_val;
        F_SLT:   alu_res = {31'b0, $signed(rs_val) < $signed(rt_val)};
        default: alu_res = rs_val + simm;
      endcase
    end
  end

  assign wr_idx  = (op == OP_R) ? rd : rt;
  assign wr_data = is_lw ? mdr : alu_out;

  always_comb begin
    state_nxt = state;
    IR_req    = 1'b0;
    CEN       = 1'b1;
    WEN       = 1'b1;
    OEN       = 1'b1;
    retire    = 1'b0;
    rf_we     = 1'b0;
    case (state)
      FETCH: begin
        IR_req = 1'b1;
        if (IR_ack) state_nxt = DECODE;
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        if (is_r_ok || is_addi)  state_nxt = WB;
        else if (is_lw || is_sw) state_nxt = MEM;
        else begin
          // beq, j and anything unrecognised complete here
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      MEM: begin
        CEN = 1'b0;
        OEN = ~is_lw;
        WEN = is_lw;
        if (mem_ack) begin
          if (is_lw) state_nxt = WB;
          else begin
            retire    = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      WB: begin
        retire    = 1'b1;
        rf_we     = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    // Reset aborts in flight: no request, no access, no retire, no write.
    if (rst) begin
      IR_req = 1'b0;
      CEN    = 1'b1;
      WEN    = 1'b1;
      OEN    = 1'b1;
      retire = 1'b0;
      rf_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      regs    <= '0;
      rs_val  <= '0;
      rt_val  <= '0;
      simm    <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: begin
          if (IR_ack) begin
            ir <= IR;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          rs_val <= rs_rd;
          rt_val <= rt_rd;
          simm   <= {{16{ir[15]}}, ir[15:0]};
        end
        EXEC: begin
          alu_out <= alu_res;
          if (is_beq && (rs_val == rt_val)) pc <= pc + {simm[29:0], 2'b00};
          if (is_j) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        MEM: begin
          if (mem_ack && is_lw) mdr <= ReadDataMem;
        end
        WB: begin
          for (int i = 1; i < NREG; i++)
            if (rf_we && (wr_idx == 5'(i))) regs[i] <= wr_data;
        end
        default: ;
      endcase
    end
  end

  assign IR_addr  = pc;
  assign A        = alu_out[ADDR_W+1:2];
  assign Data2Mem = rt_val;

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Directed bench: the bench plays instruction and data memory, runs a vector
// table of instructions and checks latency, next PC, register and memory effects.
module tb_multi_cycle_mips;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] IR_addr, IR, Data2Mem, ReadDataMem;
  logic        IR_req, IR_ack, CEN, WEN, OEN, mem_ack, retire;
  logic [6:0]  A;

  logic [31:0] IR_addr2, IR2, Data2Mem2;
  logic        IR_req2, IR_ack2, CEN2, WEN2, OEN2, retire2;
  logic [6:0]  A2;

  always #5 clk = ~clk;

  multi_cycle_mips #(.ADDR_W(7), .RESET_PC(32'h0000_0000), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .IR_addr(IR_addr), .IR_req(IR_req), .IR(IR), .IR_ack(IR_ack),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
    .ReadDataMem(ReadDataMem), .mem_ack(mem_ack), .retire(retire)
  );

  multi_cycle_mips #(.ADDR_W(7), .RESET_PC(32'hF000_0000)) u2 (
    .clk(clk), .rst(rst),
    .IR_addr(IR_addr2), .IR_req(IR_req2), .IR(IR2), .IR_ack(IR_ack2),
    .CEN(CEN2), .WEN(WEN2), .OEN(OEN2), .A(A2), .Data2Mem(Data2Mem2),
    .ReadDataMem(32'h0), .mem_ack(1'b0), .retire(retire2)
  );

  typedef struct {
    logic [31:0] instr;
    int          ir_w;
    int          mem_w;
    int          cyc;
    logic [31:0] npc;
    int          reg_i;
    logic [31:0] reg_v;
    int          wen_n;
    int          oen_n;
    bit          mem;
    logic [6:0]  a;
    logic [31:0] d;
  } vec_t;

  vec_t        vecs [20];
  logic [31:0] dmem [128];
  int          tests = 0;
  int          fails = 0;

  int          r_cyc, r_wen, r_oen, r_unstable;
  logic [6:0]  r_a;
  logic [31:0] r_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One instruction from its FETCH cycle to its retire cycle, starting and
  // ending at a falling edge. Acks are driven high outside their window to
  // show they are ignored there.
  task exec(input vec_t v);
    int  irc, mc;
    bit  done, seen;
    irc = 0; mc = 0; done = 0; seen = 0;
    r_cyc = 0; r_wen = 0; r_oen = 0; r_unstable = 0; r_a = '0; r_d = '0;
    while (!done && r_cyc < 60) begin
      r_cyc++;
      if (IR_req) begin
        if (irc == v.ir_w) begin IR_ack = 1'b1; IR = v.instr; end
        else begin IR_ack = 1'b0; IR = 32'hDEAD_BEEF; irc++; end
      end else begin
        IR_ack = 1'b1; IR = 32'hDEAD_BEEF;
      end
      if (!CEN) begin
        if (!WEN) r_wen++;
        if (!OEN) r_oen++;
        if (seen && (A !== r_a || Data2Mem !== r_d)) r_unstable++;
        seen = 1; r_a = A; r_d = Data2Mem;
        if (mc == v.mem_w) begin
          mem_ack = 1'b1;
          ReadDataMem = dmem[A];
          if (!WEN) dmem[A] = Data2Mem;
        end else begin
          mem_ack = 1'b0; ReadDataMem = 32'hBAD0_BAD0; mc++;
        end
      end else begin
        mem_ack = 1'b1; ReadDataMem = 32'h0BAD_0BAD;
      end
      #1;
      if (retire) done = 1;
      @(posedge clk); @(negedge clk);
    end
    IR_ack = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    int total;
    IR = '0; IR_ack = 1'b0; ReadDataMem = '0; mem_ack = 1'b0;
    IR2 = '0; IR_ack2 = 1'b0;
    for (int i = 0; i < 128; i++) dmem[i] = '0;

    //         instr          irw mw cyc npc       reg val           wen oen mem a     d
    vecs[0]  = '{32'h20010005, 0, 0, 4, 32'h04, 1, 32'h0000_0005, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[1]  = '{32'h2002FFFD, 0, 0, 4, 32'h08, 2, 32'hFFFF_FFFD, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[2]  = '{32'h00221820, 0, 0, 4, 32'h0C, 3, 32'h0000_0002, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[3]  = '{32'h00222022, 0, 0, 4, 32'h10, 4, 32'h0000_0008, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[4]  = '{32'h1021FFFF, 0, 0, 3, 32'h10, 1, 32'h0000_0005, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[5]  = '{32'h10220005, 0, 0, 3, 32'h14, 2, 32'hFFFF_FFFD, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[6]  = '{32'h00222824, 0, 0, 4, 32'h18, 5, 32'h0000_0005, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[7]  = '{32'h00223025, 0, 0, 4, 32'h1C, 6, 32'hFFFF_FFFD, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[8]  = '{32'h0041382A, 0, 0, 4, 32'h20, 7, 32'h0000_0001, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[9]  = '{32'h0022382A, 0, 0, 4, 32'h24, 7, 32'h0000_0000, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[10] = '{32'hAC010008, 0, 3, 7, 32'h28, 1, 32'h0000_0005, 4, 0, 1'b1, 7'd2, 32'h5};
    vecs[11] = '{32'h8C040008, 0, 3, 8, 32'h2C, 4, 32'h0000_0005, 0, 4, 1'b1, 7'd2, 32'h8};
    vecs[12] = '{32'h20000007, 0, 0, 4, 32'h30, 0, 32'h0000_0000, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[13] = '{32'h00002820, 0, 0, 4, 32'h34, 5, 32'h0000_0000, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[14] = '{32'h20090001, 0, 0, 4, 32'h38, 0, 32'h0000_0000, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[15] = '{32'h01211820, 0, 0, 4, 32'h3C, 3, 32'h0000_0005, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[16] = '{32'hFC000000, 2, 0, 5, 32'h40, 3, 32'h0000_0005, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[17] = '{32'h0041083F, 0, 0, 3, 32'h44, 1, 32'h0000_0005, 0, 0, 1'b0, 7'd0, 32'h0};
    vecs[18] = '{32'h8C06000B, 1, 0, 6, 32'h48, 6, 32'h0000_0005, 0, 1, 1'b1, 7'd2, 32'hFFFF_FFFD};
    vecs[19] = '{32'h08000004, 0, 0, 3, 32'h10, 0, 32'h0000_0000, 0, 0, 1'b0, 7'd0, 32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ir_req",  {31'b0, IR_req}, 32'd0);
    chk("rst_cen",     {31'b0, CEN},    32'd1);
    chk("rst_wen",     {31'b0, WEN},    32'd1);
    chk("rst_oen",     {31'b0, OEN},    32'd1);
    chk("rst_retire",  {31'b0, retire}, 32'd0);
    chk("rst_pc",      IR_addr,  32'h0000_0000);
    chk("rst_pc_u2",   IR_addr2, 32'hF000_0000);
    rst = 1'b0;
    #1;
    chk("ir_req_after_rst", {31'b0, IR_req}, 32'd1);

    total = 0;
    for (int i = 0; i < 20; i++) begin
      exec(vecs[i]);
      chk($sformatf("v%0d_cycles", i), r_cyc, vecs[i].cyc);
      chk($sformatf("v%0d_npc", i), IR_addr, vecs[i].npc);
      chk($sformatf("v%0d_single_retire", i), {31'b0, retire}, 32'd0);
      chk($sformatf("v%0d_wen_cycles", i), r_wen, vecs[i].wen_n);
      chk($sformatf("v%0d_oen_cycles", i), r_oen, vecs[i].oen_n);
      if (vecs[i].reg_i != 0)
        chk($sformatf("v%0d_reg%0d", i, vecs[i].reg_i), dut.regs[vecs[i].reg_i], vecs[i].reg_v);
      if (vecs[i].mem) begin
        chk($sformatf("v%0d_addr", i), {25'b0, r_a}, {25'b0, vecs[i].a});
        chk($sformatf("v%0d_data2mem", i), r_d, vecs[i].d);
        chk($sformatf("v%0d_mem_stable", i), r_unstable, 32'd0);
      end
      if (i < 3) total += r_cyc;
      if (i == 2) chk("first3_total_cycles", total, 32'd12);
    end
    chk("dmem_word2", dmem[2], 32'h0000_0005);

    // Reset during a lw MEM wait (PC is 0x10 after the closing jump).
    IR_ack = 1'b1; IR = 32'h8C070008; mem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    IR_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("abort_cen_in_mem", {31'b0, CEN}, 32'd0);
    chk("abort_oen_in_mem", {31'b0, OEN}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_no_retire", {31'b0, retire}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("abort_cen",    {31'b0, CEN},    32'd1);
    chk("abort_pc",     IR_addr,         32'h0000_0000);
    chk("abort_ir_req", {31'b0, IR_req}, 32'd0);
    chk("abort_retire", {31'b0, retire}, 32'd0);
    chk("abort_reg7",   dut.regs[7],     32'h0);
    chk("abort_reg1",   dut.regs[1],     32'h0);
    rst = 1'b0;
    #1;
    chk("abort_ir_req_rise", {31'b0, IR_req}, 32'd1);

    // j 0x40 from 0xF000_0000 keeps the top nibble.
    chk("j_start_pc", IR_addr2, 32'hF000_0000);
    IR_ack2 = 1'b1; IR2 = 32'h08000040;
    @(posedge clk); @(negedge clk);
    IR_ack2 = 1'b0;
    chk("j_decode_no_retire", {31'b0, retire2}, 32'd0);
    @(posedge clk); @(negedge clk);
    #1;
    chk("j_exec_retire", {31'b0, retire2}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("j_target",  IR_addr2, 32'hF000_0100);
    chk("j_ir_req",  {31'b0, IR_req2}, 32'd1);
    chk("j_retire_low", {31'b0, retire2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
